// File: rtl/io_uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter:
// address window, register offsets, STATUS layout and serializer states.
package io_uart_tx_pkg;

  localparam logic [3:0]  BASE_NIB_DEF    = 4'h8;
  localparam int          FIFO_AW_DEF     = 3;
  localparam logic [15:0] DEFAULT_DIV_DEF = 16'd867;

  // Register offsets, selected by io_addr[3:2].
  typedef enum logic [1:0] {
    REG_TXDATA  = 2'd0,
    REG_STATUS  = 2'd1,
    REG_BAUDDIV = 2'd2,
    REG_RSVD    = 2'd3
  } reg_off_e;

  // Bit index of the sticky overflow flag, used for write-one-to-clear.
  localparam int ST_OVF = 3;

  typedef struct packed {
    logic [23:0] rsvd;
    logic [3:0]  count;
    logic        overflow;
    logic        busy;
    logic        empty;
    logic        full;
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/io_uart_tx_fifo.sv
// Small synchronous FIFO between the TXDATA register and the serializer.
// Pushes into a full FIFO and pops from an empty one are ignored.
module io_uart_tx_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: the storage array is deliberately not reset; pointers and count
  // decide which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV registers on the
// MMU I/O bus, an 8-entry byte FIFO and a registered-output serializer.
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter logic [3:0]  BASE_NIB    = BASE_NIB_DEF,
  parameter int          FIFO_AW     = FIFO_AW_DEF,
  parameter logic [15:0] DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [7:0]  io_addr,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  output logic        uart_tx,
  output logic        tx_irq
);

  // ---------------- address decode ----------------
  logic     sel;
  reg_off_e off;
  logic     wr_txdata;
  logic     wr_status;
  logic     wr_baud;
  logic     unused_bits;

  assign sel         = io_en & (io_addr[7:4] == BASE_NIB);
  assign off         = reg_off_e'(io_addr[3:2]);
  assign wr_txdata   = sel & io_we & (off == REG_TXDATA);
  assign wr_status   = sel & io_we & (off == REG_STATUS);
  assign wr_baud     = sel & io_we & (off == REG_BAUDDIV);
  assign unused_bits = ^{io_addr[1:0], io_data_write[31:16]};

  // ---------------- FIFO ----------------
  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;

  io_uart_tx_fifo #(
    .W  (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .resetb  (resetb),
    .push_i  (wr_txdata),
    .wdata_i (io_data_write[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------- state ----------------
  tx_state_e   state_q,   state_d;
  logic [15:0] baudcnt_q, baudcnt_d;
  logic [2:0]  bitcnt_q,  bitcnt_d;
  logic [7:0]  shreg_q,   shreg_d;
  logic        tx_q,      tx_d;
  logic        ovf_q,     ovf_d;
  logic [15:0] bauddiv_q, bauddiv_d;
  logic        bit_end;

  assign bit_end = (baudcnt_q == '0);

  // NOTE: every variable gets a default before the case, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    baudcnt_d = baudcnt_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    fifo_pop  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shreg_d   = fifo_rdata;
          baudcnt_d = bauddiv_q;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bitcnt_d  = '0;
          baudcnt_d = bauddiv_q;
        end else begin
          baudcnt_d = baudcnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          // Reload from the live divider so a new BAUDDIV takes effect here.
          baudcnt_d = bauddiv_q;
          if (bitcnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            shreg_d  = shreg_q >> 1;
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          baudcnt_d = baudcnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
        else         baudcnt_d = baudcnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the next state so uart_tx comes straight from a flop.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_status && io_data_write[ST_OVF]) ovf_d = 1'b0;
    // A drop on a full FIFO wins over a same-cycle clear.
    if (wr_txdata && fifo_full)             ovf_d = 1'b1;

    bauddiv_d = wr_baud ? io_data_write[15:0] : bauddiv_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others; the comb blocks above use blocking.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= S_IDLE;
      baudcnt_q <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
      bauddiv_q <= DEFAULT_DIV;
    end else begin
      state_q   <= state_d;
      baudcnt_q <= baudcnt_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
      bauddiv_q <= bauddiv_d;
    end
  end

  // ---------------- read path and outputs ----------------
  status_t status;

  always_comb begin
    status          = '0;
    status.full     = fifo_full;
    status.empty    = fifo_empty;
    status.busy     = (state_q != S_IDLE);
    status.overflow = ovf_q;
    status.count    = 4'(fifo_count);

    io_data_read = '0;
    if (sel) begin
      case (off)
        REG_STATUS:  io_data_read = status;
        REG_BAUDDIV: io_data_read = {16'h0000, bauddiv_q};
        default:     io_data_read = '0;
      endcase
    end
  end

  assign uart_tx = tx_q;
  assign tx_irq  = fifo_empty & (state_q == S_IDLE);

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed + randomized bench for io_uart_tx: register map, frame waveforms,
// FIFO overflow, baud changes mid-frame and reset during a frame.
module tb_io_uart_tx;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic [7:0]  io_addr = '0;
  logic        io_en = 1'b0;
  logic        io_we = 1'b0;
  logic [31:0] io_data_write = '0;
  logic [31:0] io_data_read;
  logic        uart_tx;
  logic        tx_irq;

  always #5 clk = ~clk;

  io_uart_tx dut (
    .clk           (clk),
    .resetb        (resetb),
    .io_addr       (io_addr),
    .io_en         (io_en),
    .io_we         (io_we),
    .io_data_write (io_data_write),
    .io_data_read  (io_data_read),
    .uart_tx       (uart_tx),
    .tx_irq        (tx_irq)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic io_write(input logic [7:0] a, input logic [31:0] d);
    io_en = 1'b1; io_we = 1'b1; io_addr = a; io_data_write = d;
    @(negedge clk);
    io_en = 1'b0; io_we = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] a, output logic [31:0] d);
    io_en = 1'b1; io_we = 1'b0; io_addr = a;
    #1;
    d = io_data_read;
    io_en = 1'b0;
  endtask

  // Serial receiver: samples each bit mid-period at a fixed baud.
  logic       rx_en = 1'b0;
  int         rx_period = 1;
  int         rx_frame_err = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  initial begin : receiver
    logic [9:0] fr;
    int p;
    forever begin
      @(negedge clk);
      if (rx_en && resetb && uart_tx === 1'b0) begin
        p = rx_period;
        repeat (p / 2) @(negedge clk);
        fr[0] = uart_tx;
        for (int i = 1; i < 10; i++) begin
          repeat (p) @(negedge clk);
          fr[i] = uart_tx;
        end
        if (fr[0] !== 1'b0 || fr[9] !== 1'b1) rx_frame_err++;
        rx_q.push_back(fr[8:1]);
      end
    end
  end

  // Waveform capture against a frame built from the 8N1 rules.
  logic cap_tx  [128];
  logic cap_irq [128];
  logic exp_tx  [128];
  logic exp_irq [128];

  task automatic run_wave(input string tag, input logic [7:0] d, input int n,
                          input int chg_at, input logic [15:0] chg_val,
                          input int p_lo, input int sw_bit, input int p_hi);
    int   idx;
    int   per;
    logic v;
    io_write(8'h80, {24'h0, d});
    for (int i = 0; i < n; i++) begin
      cap_tx[i]  = uart_tx;
      cap_irq[i] = tx_irq;
      if (i == chg_at) begin
        io_en = 1'b1; io_we = 1'b1; io_addr = 8'h88; io_data_write = {16'h0, chg_val};
      end else begin
        io_en = 1'b0; io_we = 1'b0;
      end
      @(negedge clk);
    end
    io_en = 1'b0; io_we = 1'b0;
    exp_tx[0] = 1'b1; exp_irq[0] = 1'b0;
    idx = 1;
    for (int j = 0; j < 10; j++) begin
      per = (j < sw_bit) ? p_lo : p_hi;
      v   = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : d[j-1];
      for (int c = 0; c < per; c++) begin
        exp_tx[idx] = v; exp_irq[idx] = 1'b0; idx++;
      end
    end
    while (idx < n) begin
      exp_tx[idx] = 1'b1; exp_irq[idx] = 1'b1; idx++;
    end
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_tx[%0d]", tag, i), cap_tx[i], exp_tx[i]);
      check($sformatf("%s_irq[%0d]", tag, i), cap_irq[i], exp_irq[i]);
    end
  endtask

  // Burst of n random bytes on consecutive edges; the model tracks FIFO
  // occupancy and when the serializer is free to take the next byte.
  task automatic burst(input string tag, input int n, input int b);
    logic [7:0]  v;
    logic        pop;
    logic        busy;
    logic        m_ovf;
    int          m_cnt;
    int          m_free;
    logic [31:0] st;
    logic [31:0] exp_st;
    m_cnt = 0; m_free = 0; m_ovf = 1'b0;
    for (int e = 1; e <= n; e++) begin
      v = 8'($urandom);
      io_en = 1'b1; io_we = 1'b1; io_addr = 8'h80; io_data_write = {24'h0, v};
      pop = (m_cnt > 0) && (e >= m_free);
      if (m_cnt == 8) m_ovf = 1'b1;
      else begin
        m_cnt++;
        exp_q.push_back(v);
      end
      if (pop) begin
        m_cnt--;
        m_free = e + 10 * (b + 1) + 1;
      end
      @(negedge clk);
    end
    io_en = 1'b0; io_we = 1'b0;
    busy   = (m_free != 0) && (n < m_free - 1);
    exp_st = {24'h0, 4'(m_cnt), m_ovf, busy, (m_cnt == 0), (m_cnt == 8)};
    io_read(8'h84, st);
    check({tag, "_status"}, st, exp_st);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (tx_irq !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, tx_irq, 1);
  endtask

  task automatic drain(input string tag);
    wait_idle(tag, 3000);
    cyc(2);
    check({tag, "_rx_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte[%0d]", tag, i), rx_q[i], exp_q[i]);
    check({tag, "_framing"}, rx_frame_err, 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] rd;
    int          lows;
    int          b;

    // Reset state
    cyc(3);
    resetb = 1'b1;
    cyc(1);
    io_read(8'h84, rd); check("t1_status", rd, 32'h0000_0002);
    io_read(8'h88, rd); check("t1_bauddiv", rd, 32'd867);
    check("t1_tx", uart_tx, 1);
    check("t1_irq", tx_irq, 1);

    // Decode: reserved, TXDATA, other windows and unqualified access read 0
    io_read(8'h8C, rd); check("t4_rsvd", rd, 0);
    io_read(8'h40, rd); check("t4_other_win", rd, 0);
    io_read(8'h80, rd); check("t4_txdata_rd", rd, 0);
    io_en = 1'b0; io_addr = 8'h88; #1;
    check("t4_no_en", io_data_read, 0);
    io_write(8'h48, 32'h5);
    io_write(8'h40, 32'hAA);
    io_en = 1'b0; io_we = 1'b1; io_addr = 8'h80; io_data_write = 32'h77;
    @(negedge clk);
    io_we = 1'b0;
    cyc(3);
    io_read(8'h88, rd); check("t4_baud_kept", rd, 32'd867);
    io_read(8'h84, rd); check("t4_status_kept", rd, 32'h2);
    check("t4_tx_idle", uart_tx, 1);

    // 0x55 at BAUDDIV=3, then a divider change 3->7 during data bit 2
    io_write(8'h88, 32'd3);
    run_wave("t2", 8'h55, 44, -1, 16'd0, 4, 10, 4);
    run_wave("t6", 8'h55, 68, 13, 16'd7, 4, 4, 8);
    io_read(8'h88, rd); check("t6_baud", rd, 32'd7);

    // BAUDDIV=0, ten back-to-back writes: overflow and W1C
    io_write(8'h88, 32'd0);
    rx_period = 1; rx_en = 1'b1;
    exp_q.delete(); rx_q.delete();
    burst("t3", 10, 0);
    io_write(8'h84, 32'h8);
    io_read(8'h84, rd); check("t3_w1c", rd[3], 0);
    drain("t3");

    // Random divider and burst length
    for (int r = 0; r < 3; r++) begin
      b = $urandom_range(0, 5);
      io_write(8'h88, 32'(b));
      rx_period = b + 1;
      exp_q.delete(); rx_q.delete();
      burst($sformatf("rnd%0d", r), $urandom_range(1, 10), b);
      io_write(8'h84, 32'h8);
      drain($sformatf("rnd%0d", r));
    end
    rx_en = 1'b0;

    // Reset during data bit 4 of 0xA3 with three bytes queued
    io_write(8'h88, 32'd3);
    io_write(8'h80, 32'hA3);
    io_write(8'h80, 32'h11);
    io_write(8'h80, 32'h22);
    io_write(8'h80, 32'h33);
    io_read(8'h84, rd); check("t5_status_pre", rd, 32'h34);
    cyc(19);
    check("t5_bit4", uart_tx, 0);
    resetb = 1'b0;
    #1;
    check("t5_tx_in_reset", uart_tx, 1);
    check("t5_irq_in_reset", tx_irq, 1);
    @(negedge clk);
    resetb = 1'b1;
    io_read(8'h84, rd); check("t5_status_post", rd, 32'h2);
    io_read(8'h88, rd); check("t5_baud_post", rd, 32'd867);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("t5_quiet", lows, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
